// File: rtl/unpadding_if.sv
// Stream bundle for the unpadding stage: padded input beats in, cropped beats out.
interface unpadding_if #(
  parameter int unsigned DW = 32
) ();
  logic          d_valid;
  logic          d_ready;
  logic [DW-1:0] d_value;
  logic          d_last_elm;
  logic          q_valid;
  logic          q_ready;
  logic [DW-1:0] q_value;
  logic          q_new_tile_k;
  logic          q_last_w;
  logic          q_last_elm;

  // Producer/consumer side (the bench)
  modport master (
    output d_valid, d_value, d_last_elm, q_ready,
    input  d_ready, q_valid, q_value, q_new_tile_k, q_last_w, q_last_elm
  );

  // Unpadding block side
  modport slave (
    input  d_valid, d_value, d_last_elm, q_ready,
    output d_ready, q_valid, q_value, q_new_tile_k, q_last_w, q_last_elm
  );
endinterface

// File: rtl/unpadding.sv
// Crops the zero border from a padded raster stream and regenerates tile flags.
module unpadding #(
  parameter int unsigned SZI         = 4,
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned MAX_PADDING = 4,
  parameter int unsigned MAX_W       = 64,
  parameter int unsigned MAX_H       = 64
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           layer_params_valid,
  input  logic [$clog2(MAX_PADDING)-1:0] padding,
  input  logic [$clog2(MAX_W)-1:0]       size_w,
  input  logic [$clog2(MAX_H)-1:0]       size_h,
  unpadding_if.slave                     io,
  output logic                           busy,
  output logic                           err_last_mismatch
);

  localparam int unsigned DW = SZI * A_WIDTH;
  localparam int unsigned CW = $clog2(MAX_W) + 1;
  localparam int unsigned RW = $clog2(MAX_H) + 1;

  typedef struct packed {
    logic [DW-1:0] value;
    logic          new_tile_k;
    logic          last_w;
    logic          last_elm;
  } entry_t;

  // Latched geometry
  logic          params_loaded;
  logic [CW-1:0] pad_col, col_end, col_last, col_max;
  logic [RW-1:0] pad_row, row_end, row_last, row_max;

  // Raster position and output buffer
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  entry_t        buf0, buf1;
  logic [1:0]    count;
  logic [1:0]    count_n;
  logic          q_valid_r;

  logic   accept, keep, push, pop, at_col_max, at_row_max;
  entry_t beat;

  // Handshake, keep decision and flag generation for the current input position
  always_comb begin
    accept           = io.d_valid & io.d_ready;
    keep             = (row >= pad_row) && (row < row_end) &&
                       (col >= pad_col) && (col < col_end);
    at_col_max       = (col == col_max);
    at_row_max       = (row == row_max);
    beat.value       = io.d_value;
    beat.new_tile_k  = (row == pad_row) && (col == pad_col);
    beat.last_w      = (col == col_last);
    beat.last_elm    = (col == col_last) && (row == row_last);
    push             = accept & keep;
    pop              = q_valid_r & io.q_ready;
    count_n          = count + 2'(push) - 2'(pop);
  end

  assign io.d_ready     = params_loaded & (count != 2'd2) & ~layer_params_valid;
  assign io.q_valid     = q_valid_r;
  assign io.q_value     = buf0.value;
  assign io.q_new_tile_k = buf0.new_tile_k;
  assign io.q_last_w    = buf0.last_w;
  assign io.q_last_elm  = buf0.last_elm;
  assign busy           = (row != '0) | (col != '0) | (count != 2'd0);

  // Parameter latch, raster counters and last-element consistency check
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      params_loaded     <= 1'b0;
      pad_col           <= '0;
      col_end           <= '0;
      col_last          <= '0;
      col_max           <= '0;
      pad_row           <= '0;
      row_end           <= '0;
      row_last          <= '0;
      row_max           <= '0;
      col               <= '0;
      row               <= '0;
      err_last_mismatch <= 1'b0;
    end else if (layer_params_valid) begin
      params_loaded <= 1'b1;
      pad_col       <= CW'(padding);
      col_end       <= CW'(size_w) + CW'(padding);
      col_last      <= CW'(size_w) + CW'(padding) - CW'(1);
      col_max       <= CW'(size_w) + (CW'(padding) << 1) - CW'(1);
      pad_row       <= RW'(padding);
      row_end       <= RW'(size_h) + RW'(padding);
      row_last      <= RW'(size_h) + RW'(padding) - RW'(1);
      row_max       <= RW'(size_h) + (RW'(padding) << 1) - RW'(1);
      col           <= '0;
      row           <= '0;
    end else if (accept) begin
      if (io.d_last_elm && !(at_col_max && at_row_max)) begin
        // Early end-of-frame from upstream: resynchronise on the next beat
        err_last_mismatch <= 1'b1;
        col               <= '0;
        row               <= '0;
      end else if (at_col_max) begin
        col <= '0;
        if (at_row_max) begin
          row <= '0;
          if (!io.d_last_elm) err_last_mismatch <= 1'b1;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Two-entry output buffer; buf0 is the head presented on q_*
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf0      <= '0;
      buf1      <= '0;
      count     <= 2'd0;
      q_valid_r <= 1'b0;
    end else begin
      if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
        buf0 <= beat;
      end else if (pop && (count == 2'd2)) begin
        buf0 <= buf1;
      end
      if (push && (count == 2'd1) && !pop) begin
        buf1 <= beat;
      end
      count     <= count_n;
      q_valid_r <= (count_n != 2'd0);
    end
  end

endmodule

// File: tb/tb_unpadding.sv
// Self-checking bench for unpadding: randomized and directed frames against a raster model.
module tb_unpadding;

  localparam int unsigned SZI     = 4;
  localparam int unsigned A_WIDTH = 8;
  localparam int unsigned DW      = SZI * A_WIDTH;

  typedef struct packed {
    logic [DW-1:0] v;
    logic          ntk;
    logic          lw;
    logic          le;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       lpv;
  logic [1:0] padding;
  logic [5:0] size_w;
  logic [5:0] size_h;
  logic       busy;
  logic       err;

  unpadding_if #(.DW(DW)) bus ();

  unpadding #(
    .SZI(SZI), .A_WIDTH(A_WIDTH), .MAX_PADDING(4), .MAX_W(64), .MAX_H(64)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .layer_params_valid(lpv),
    .padding(padding),
    .size_w(size_w),
    .size_h(size_h),
    .io(bus.slave),
    .busy(busy),
    .err_last_mismatch(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] in_v[$];
  bit            in_l[$];
  int            acc_cyc[$];
  beat_t         exp_q[$];
  int            exp_idx[$];
  obs_t          out_q[$];
  bit            dr_log[4096];

  int mP, mW, mH, mpos;
  bit merr;
  int qr_mode, stall_lo, stall_hi;
  int tests = 0;
  int fails = 0;

  // Output monitor and d_ready log, sampled mid-cycle
  always @(negedge clk) begin
    dr_log[cyc % 4096] <= bus.d_ready;
    if (resetn && bus.q_valid && bus.q_ready)
      out_q.push_back('{b: '{bus.q_value, bus.q_new_tile_k, bus.q_last_w, bus.q_last_elm}, cyc: cyc});
  end

  function automatic bit qr_val();
    case (qr_mode)
      1:       return !(cyc >= stall_lo && cyc <= stall_hi);
      2:       return ($urandom_range(3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: place beat at linear frame position, crop by index arithmetic
  function automatic void model_beat(input logic [DW-1:0] v, input bit last, input int idx);
    int pw, ph, r, c;
    pw = mW + 2 * mP;
    ph = mH + 2 * mP;
    r  = mpos / pw;
    c  = mpos % pw;
    if (r >= mP && r < mH + mP && c >= mP && c < mW + mP) begin
      exp_q.push_back('{v, (r == mP) && (c == mP), c == mW + mP - 1,
                        (c == mW + mP - 1) && (r == mH + mP - 1)});
      exp_idx.push_back(idx);
    end
    if (last && mpos != pw * ph - 1) begin
      merr = 1'b1;
      mpos = 0;
    end else begin
      if (mpos == pw * ph - 1 && !last) merr = 1'b1;
      mpos = (mpos + 1) % (pw * ph);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.q_ready = qr_val();
  endtask

  task automatic clear_all();
    in_v.delete(); in_l.delete(); acc_cyc.delete();
    exp_q.delete(); exp_idx.delete(); out_q.delete();
  endtask

  task automatic load(input int p, input int w, input int h);
    padding = 2'(p); size_w = 6'(w); size_h = 6'(h);
    lpv = 1'b1;
    mP = p; mW = w; mH = h; mpos = 0;
    @(negedge clk);
    tests++;
    if (bus.d_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_dready got=%b exp=0", bus.d_ready);
    end
    tick();
    lpv = 1'b0;
  endtask

  task automatic drive(input int gap_pct);
    int n;
    for (int i = 0; i < in_v.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.d_valid = 1'b0;
        tick();
      end
      bus.d_valid    = 1'b1;
      bus.d_value    = in_v[i];
      bus.d_last_elm = in_l[i];
      n = 0;
      @(negedge clk);
      while (!bus.d_ready && n < 400) begin
        tick();
        @(negedge clk);
        n++;
      end
      if (!bus.d_ready) begin
        tests++; fails++;
        $display("FAIL drive_timeout beat=%0d got d_ready=0 exp=1", i);
        tick();
        bus.d_valid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      model_beat(in_v[i], in_l[i], acc_cyc.size() - 1);
      tick();
    end
    bus.d_valid    = 1'b0;
    bus.d_last_elm = 1'b0;
  endtask

  task automatic drain(input int n_exp);
    for (int k = 0; k < 300 && out_q.size() < n_exp; k++) tick();
    repeat (4) tick();
  endtask

  task automatic fill_frame(input int base, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      in_v.push_back(DW'(base + i));
      in_l.push_back(i == last_at);
    end
  endtask

  task automatic test_reset();
    bus.d_valid = 1'b0; bus.d_value = '0; bus.d_last_elm = 1'b0; bus.q_ready = 1'b1;
    lpv = 1'b0; padding = '0; size_w = '0; size_h = '0;
    qr_mode = 0; stall_lo = 0; stall_hi = 0; merr = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    tests++;
    if ({bus.q_valid, bus.d_ready, busy, err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus.q_valid, bus.d_ready, busy, err});
    end
    tests++;
    if ({bus.q_value, bus.q_new_tile_k, bus.q_last_w, bus.q_last_elm} !== '0) begin
      fails++;
      $display("FAIL reset_q got=%h exp=0", {bus.q_value, bus.q_new_tile_k, bus.q_last_w, bus.q_last_elm});
    end
    resetn = 1'b1;
    repeat (2) tick();
    tests++;
    if (bus.d_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_noparams_dready got=%b exp=0", bus.d_ready);
    end
  endtask

  task automatic test_crop();
    clear_all();
    qr_mode = 0;
    load(1, 2, 2);
    fill_frame(0, 16, 15);
    drive(0);
    drain(exp_q.size());
    tests++;
    if (out_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL crop_count got=%0d exp=%0d", out_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      tests++;
      if (out_q[k].b !== exp_q[k]) begin
        fails++;
        $display("FAIL crop_beat[%0d] got=%h exp=%h", k, out_q[k].b, exp_q[k]);
      end
      tests++;
      if (out_q[k].cyc !== acc_cyc[exp_idx[k]] + 1) begin
        fails++;
        $display("FAIL crop_latency[%0d] got=%0d exp=%0d", k, out_q[k].cyc, acc_cyc[exp_idx[k]] + 1);
      end
    end
    tests++;
    if ({err, busy} !== {merr, 1'b0}) begin
      fails++;
      $display("FAIL crop_err_busy got=%b exp=%b", {err, busy}, {merr, 1'b0});
    end
  endtask

  task automatic test_passthrough();
    clear_all();
    load(0, 3, 1);
    in_v.push_back(DW'(7)); in_v.push_back(DW'(8)); in_v.push_back(DW'(9));
    in_l.push_back(1'b0);   in_l.push_back(1'b0);   in_l.push_back(1'b1);
    drive(0);
    drain(exp_q.size());
    tests++;
    if (out_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL pass_count got=%0d exp=%0d", out_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      tests++;
      if (out_q[k].b !== exp_q[k]) begin
        fails++;
        $display("FAIL pass_beat[%0d] got=%h exp=%h", k, out_q[k].b, exp_q[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int t0;
    clear_all();
    load(1, 2, 2);
    fill_frame(0, 16, 15);
    t0       = cyc;
    stall_lo = t0 + 6;
    stall_hi = t0 + 11;
    qr_mode  = 1;
    drive(0);
    drain(exp_q.size());
    qr_mode = 0;
    tests++;
    if ({dr_log[(t0 + 6) % 4096], dr_log[(t0 + 7) % 4096], dr_log[(t0 + 12) % 4096], dr_log[(t0 + 13) % 4096]} !== 4'b1001) begin
      fails++;
      $display("FAIL bp_dready got=%b exp=1001",
               {dr_log[(t0 + 6) % 4096], dr_log[(t0 + 7) % 4096], dr_log[(t0 + 12) % 4096], dr_log[(t0 + 13) % 4096]});
    end
    tests++;
    if (out_q.size() == 0 || out_q[0].cyc !== t0 + 12) begin
      fails++;
      $display("FAIL bp_first_pop got=%0d exp=%0d", out_q.size() == 0 ? -1 : out_q[0].cyc, t0 + 12);
    end
    tests++;
    if (out_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL bp_count got=%0d exp=%0d", out_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      tests++;
      if (out_q[k].b !== exp_q[k]) begin
        fails++;
        $display("FAIL bp_beat[%0d] got=%h exp=%h", k, out_q[k].b, exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    load(1, 2, 2);
    fill_frame(0, 16, 15);
    fill_frame(100, 16, 15);
    drive(0);
    drain(exp_q.size());
    tests++;
    if (out_q.size() !== 8 || exp_q.size() !== 8) begin
      fails++;
      $display("FAIL b2b_count got=%0d exp=8", out_q.size());
    end
    tests++;
    if (acc_cyc.size() < 17 || acc_cyc[16] !== acc_cyc[15] + 1) begin
      fails++;
      $display("FAIL b2b_gap got=%0d exp=%0d", acc_cyc.size() < 17 ? -1 : acc_cyc[16], acc_cyc[15] + 1);
    end
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      tests++;
      if (out_q[k].b !== exp_q[k] || out_q[k].cyc !== acc_cyc[exp_idx[k]] + 1) begin
        fails++;
        $display("FAIL b2b_beat[%0d] got=%h@%0d exp=%h@%0d", k, out_q[k].b, out_q[k].cyc,
                 exp_q[k], acc_cyc[exp_idx[k]] + 1);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int p, w, h, n;
      clear_all();
      p = $urandom_range(3);
      w = $urandom_range(5, 1);
      h = $urandom_range(4, 1);
      qr_mode = 0;
      load(p, w, h);
      qr_mode = 2;
      n = (w + 2 * p) * (h + 2 * p);
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < n; i++) begin
          in_v.push_back(DW'($urandom));
          in_l.push_back(i == n - 1);
        end
      end
      drive(30);
      drain(exp_q.size());
      qr_mode = 0;
      tests++;
      if (out_q.size() !== exp_q.size()) begin
        fails++;
        $display("FAIL rand%0d_count got=%0d exp=%0d (P=%0d W=%0d H=%0d)", it, out_q.size(), exp_q.size(), p, w, h);
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
        tests++;
        if (out_q[k].b !== exp_q[k]) begin
          fails++;
          $display("FAIL rand%0d_beat[%0d] got=%h exp=%h", it, k, out_q[k].b, exp_q[k]);
        end
      end
      tests++;
      if (err !== merr) begin
        fails++;
        $display("FAIL rand%0d_err got=%b exp=%b", it, err, merr);
      end
    end
  endtask

  task automatic test_mismatch();
    clear_all();
    qr_mode = 0;
    load(1, 2, 2);
    fill_frame(0, 10, 9);
    drive(0);
    drain(exp_q.size());
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL mm_err got=%b exp=1", err);
    end
    tests++;
    if (out_q.size() !== 3 || out_q[2].b.v !== DW'(9)) begin
      fails++;
      $display("FAIL mm_partial got=%0d beats exp=3 ending in 9", out_q.size());
    end
    in_v.delete(); in_l.delete();
    fill_frame(0, 16, 15);
    drive(0);
    drain(exp_q.size());
    tests++;
    if (out_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL mm_count got=%0d exp=%0d", out_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      tests++;
      if (out_q[k].b !== exp_q[k]) begin
        fails++;
        $display("FAIL mm_beat[%0d] got=%h exp=%h", k, out_q[k].b, exp_q[k]);
      end
    end
    tests++;
    if (err !== merr) begin
      fails++;
      $display("FAIL mm_sticky got=%b exp=%b", err, merr);
    end
  endtask

  task automatic test_reset_midframe();
    beat_t want;
    clear_all();
    qr_mode = 0;
    load(1, 2, 2);
    fill_frame(0, 7, -1);
    drive(0);
    resetn = 1'b0;
    merr   = 1'b0;
    #2;
    tests++;
    if ({bus.q_valid, busy, bus.d_ready, err} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_mid_state got=%b exp=0000", {bus.q_valid, busy, bus.d_ready, err});
    end
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    clear_all();
    load(2, 1, 1);
    fill_frame(0, 25, 24);
    drive(0);
    drain(exp_q.size());
    want = '{DW'(12), 1'b1, 1'b1, 1'b1};
    tests++;
    if (out_q.size() !== 1 || exp_q.size() !== 1) begin
      fails++;
      $display("FAIL rst_mid_count got=%0d exp=1", out_q.size());
    end
    tests++;
    if (out_q.size() == 0 || out_q[0].b !== want || exp_q[0] !== want) begin
      fails++;
      $display("FAIL rst_mid_beat got=%h exp=%h", out_q.size() == 0 ? '0 : out_q[0].b, want);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_err got=%b exp=0", err);
    end
  endtask

  initial begin
    test_reset();
    test_crop();
    test_passthrough();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mismatch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
